ysyx_23060191_mem_arbiter: RTL and testbench
============================================

YSYX_23060191_MEM_ARBITER -- requirements
Module: ysyx_23060191_MEM_ARBITER

Interface
REQ-001 SHALL have parameter: DW, 32, address/data width (equal to CPU_WIDTH).
REQ-002 SHALL have ports (name direction width meaning):
- clk in 1: single clock, all state on rising edge.
- rst in 1: asynchronous, active-high reset.
- m0_req_valid in 1: IFU fetch request.
- m0_req_ready out 1: IFU request accepted.
- m0_addr in DW: fetch address.
- m0_rsp_valid out 1: fetch data valid.
- m0_rsp_ready in 1: IFU accepts data.
- m0_rdata out DW: fetched instruction.
- m1_req_valid in 1: LSU request.
- m1_req_ready out 1: LSU request accepted.
- m1_addr in DW: LSU address.
- m1_wen in 1: 1 = store, 0 = load.
- m1_wdata in DW: store data.
- m1_wmask in 4: byte strobes.
- m1_rsp_valid out 1: LSU response valid.
- m1_rsp_ready in 1: LSU accepts response.
- m1_rdata out DW: load data.
- s_req_valid out 1: memory request.
- s_req_ready in 1: memory accepts request.
- s_addr out DW; s_wen out 1; s_wdata out DW; s_wmask out 4: forwarded request fields.
- s_rsp_valid in 1: memory response valid.
- s_rsp_ready out 1: arbiter accepts response.
- s_rdata in DW: memory read data.

Function
REQ-003 SHALL implement a registered FSM with states IDLE, REQ0, RSP0, REQ1, RSP1, plus a 1-bit last_grant register.
REQ-004 In IDLE, SHALL:
- go to REQ0 if only m0_req_valid is asserted.
- go to REQ1 if only m1_req_valid is asserted.
- if both are asserted, grant the master not equal to last_grant (round-robin).
- stay in IDLE if neither is asserted.
REQ-005 On entering REQ0/REQ1, SHALL set last_grant to 0/1 respectively.
REQ-006 In IDLE, SHALL drive every handshake output to 0; there is one cycle of arbitration latency before any request reaches memory.
REQ-007 In REQx, SHALL:
- drive s_req_valid = mx_req_valid and mx_req_ready = s_req_ready combinationally.
- drive s_addr from mx_addr.
- for m0: s_wen=0, s_wdata=0, s_wmask=0.
- for m1: s_wen, s_wdata, s_wmask taken from m1 inputs.
REQ-008 SHALL move REQx->RSPx on the cycle where s_req_valid && s_req_ready.
REQ-009 If mx_req_valid deasserts in REQx, SHALL remain in REQx with s_req_valid=0 (no abort path).
REQ-010 In RSPx, SHALL drive mx_rsp_valid = s_rsp_valid, s_rsp_ready = mx_rsp_ready, mx_rdata = s_rdata, and force s_req_valid=0.
REQ-011 SHALL move RSPx->IDLE on s_rsp_valid && s_rsp_ready; a store response completes identically, with m1_rdata don't-care.
REQ-012 The non-granted master SHALL see req_ready=0, rsp_valid=0 and rdata=0 in every state.
REQ-013 SHALL allow at most one outstanding memory transaction; minimum transaction time is 3 cycles (IDLE, REQ, RSP), with zero-wait memory.
REQ-014 New requests arriving in REQx/RSPx SHALL be held off (ready=0) until the FSM returns to IDLE.
REQ-015 A same-cycle response handshake and new request SHALL NOT be granted in that cycle; the grant occurs in the following IDLE cycle.

Reset
REQ-016 rst=1 SHALL immediately (asynchronously) force state=IDLE and last_grant=1, so m0 wins the first contention.
REQ-017 With rst=1, all outputs SHALL be 0.
REQ-018 Reset asserted during REQx/RSPx SHALL drop the transaction with no response delivered; after deassertion the FSM SHALL arbitrate afresh.

Verification
REQ-019 m0 only, addr=0x80000000, memory ready and responds with 0x00100073 one cycle later -> m0_req_ready pulses in cycle 2, m0_rsp_valid with m0_rdata=0x00100073 in cycle 3, s_wen=0 throughout.
REQ-020 Both valid out of reset -> m0 served first; m1 store (addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF) is then forwarded with s_wen=1; last_grant ends at 1.
REQ-021 Both masters continuously valid for 4 transactions -> grant order m0, m1, m0, m1.
REQ-022 Back-pressure: s_req_ready held 0 for 5 cycles, then m1_rsp_ready held 0 for 3 cycles -> FSM holds in REQ1 then RSP1, s_addr stable, exactly one response delivered.
REQ-023 rst pulsed while in RSP0 -> outputs 0 in the same cycle, state IDLE, no m0_rsp_valid; a pending m1 request is granted in the first cycle after rst deasserts.

Source files
------------

// File: rtl/ysyx_23060191_mem_arbiter.sv
// Two-master, single-slave memory arbiter: IFU (m0) and LSU (m1) share one memory port.
// One transaction in flight at a time; round-robin on contention, m0 first after reset.
module ysyx_23060191_mem_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // IFU port
  input  logic          m0_req_valid,
  output logic          m0_req_ready,
  input  logic [DW-1:0] m0_addr,
  output logic          m0_rsp_valid,
  input  logic          m0_rsp_ready,
  output logic [DW-1:0] m0_rdata,
  // LSU port
  input  logic          m1_req_valid,
  output logic          m1_req_ready,
  input  logic [DW-1:0] m1_addr,
  input  logic          m1_wen,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_wmask,
  output logic          m1_rsp_valid,
  input  logic          m1_rsp_ready,
  output logic [DW-1:0] m1_rdata,
  // memory port
  output logic          s_req_valid,
  input  logic          s_req_ready,
  output logic [DW-1:0] s_addr,
  output logic          s_wen,
  output logic [DW-1:0] s_wdata,
  output logic [3:0]    s_wmask,
  input  logic          s_rsp_valid,
  output logic          s_rsp_ready,
  input  logic [DW-1:0] s_rdata,
  // debug: current FSM state
  output logic [2:0]    dbg_state
);

  // Handshake rule on every channel: a beat transfers on the rising edge where
  // valid && ready; the arbiter only routes valid/ready, it never waits on ready to raise valid.

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ0 = 3'd1;
  localparam logic [2:0] RSP0 = 3'd2;
  localparam logic [2:0] REQ1 = 3'd3;
  localparam logic [2:0] RSP1 = 3'd4;

  logic [2:0] r_state;
  logic       r_last_grant;
  logic [2:0] w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_req_valid && m1_req_valid)
          w_next = r_last_grant ? REQ0 : REQ1;
        else if (m0_req_valid)
          w_next = REQ0;
        else if (m1_req_valid)
          w_next = REQ1;
      end
      REQ0:    if (m0_req_valid && s_req_ready) w_next = RSP0;
      RSP0:    if (s_rsp_valid && m0_rsp_ready) w_next = IDLE;
      REQ1:    if (m1_req_valid && s_req_ready) w_next = RSP1;
      RSP1:    if (s_rsp_valid && m1_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == REQ0) r_last_grant <= 1'b0;
      if (r_state == IDLE && w_next == REQ1) r_last_grant <= 1'b1;
    end
  end

  // Everything is zero unless the current state routes it; IDLE routes nothing.
  always_comb begin
    m0_req_ready = 1'b0;
    m0_rsp_valid = 1'b0;
    m0_rdata     = '0;
    m1_req_ready = 1'b0;
    m1_rsp_valid = 1'b0;
    m1_rdata     = '0;
    s_req_valid  = 1'b0;
    s_addr       = '0;
    s_wen        = 1'b0;
    s_wdata      = '0;
    s_wmask      = 4'h0;
    s_rsp_ready  = 1'b0;
    case (r_state)
      REQ0: begin
        s_req_valid  = m0_req_valid;
        m0_req_ready = s_req_ready;
        s_addr       = m0_addr;
      end
      RSP0: begin
        m0_rsp_valid = s_rsp_valid;
        s_rsp_ready  = m0_rsp_ready;
        m0_rdata     = s_rdata;
      end
      REQ1: begin
        s_req_valid  = m1_req_valid;
        m1_req_ready = s_req_ready;
        s_addr       = m1_addr;
        s_wen        = m1_wen;
        s_wdata      = m1_wdata;
        s_wmask      = m1_wmask;
      end
      RSP1: begin
        m1_rsp_valid = s_rsp_valid;
        s_rsp_ready  = m1_rsp_ready;
        m1_rdata     = s_rdata;
      end
      default: ;
    endcase
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_ysyx_23060191_mem_arbiter.sv
// Directed bench for ysyx_23060191_mem_arbiter: fetch, contention/store, round-robin,
// back-pressure, held-off requests and reset in the middle of a transaction.
module tb_ysyx_23060191_mem_arbiter;

  localparam int DW = 32;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ0 = 3'd1;
  localparam logic [2:0] S_RSP0 = 3'd2;
  localparam logic [2:0] S_REQ1 = 3'd3;
  localparam logic [2:0] S_RSP1 = 3'd4;

  logic          clk;
  logic          rst;
  logic          m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready;
  logic [DW-1:0] m0_addr, m0_rdata;
  logic          m1_req_valid, m1_req_ready, m1_wen, m1_rsp_valid, m1_rsp_ready;
  logic [DW-1:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]    m1_wmask;
  logic          s_req_valid, s_req_ready, s_wen, s_rsp_valid, s_rsp_ready;
  logic [DW-1:0] s_addr, s_wdata, s_rdata;
  logic [3:0]    s_wmask;
  logic [2:0]    dbg_state;
  logic [141:0]  all_out;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_23060191_mem_arbiter #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rdata(m1_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rdata(s_rdata),
    .dbg_state(dbg_state)
  );

  assign all_out = {m0_req_ready, m0_rsp_valid, m0_rdata, m1_req_ready, m1_rsp_valid,
                    m1_rdata, s_req_valid, s_addr, s_wen, s_wdata, s_wmask, s_rsp_ready,
                    dbg_state};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    m0_req_valid = 1'b0; m0_addr = '0; m0_rsp_ready = 1'b0;
    m1_req_valid = 1'b0; m1_addr = '0; m1_wen = 1'b0; m1_wdata = '0; m1_wmask = 4'h0;
    m1_rsp_ready = 1'b0;
    s_req_ready = 1'b0; s_rsp_valid = 1'b0; s_rdata = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1; m0_addr = 32'h1234_5678;
    s_req_ready = 1'b1; s_rsp_valid = 1'b1; s_rdata = 32'hA5A5_A5A5;
    step();
    step();
    n_cmp++;
    if (all_out !== '0) begin
      $display("FAIL reset_outputs: got %h expected 0", all_out); n_err++;
    end
    drive_idle();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (dbg_state !== S_IDLE) begin
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); n_err++;
    end
  endtask

  task automatic test_m0_fetch();
    // cycle 1: IDLE, request visible but not yet forwarded
    step();
    m0_req_valid = 1'b1; m0_addr = 32'h8000_0000; m0_rsp_ready = 1'b1; s_req_ready = 1'b1;
    #1;
    n_cmp++;
    if ({m0_req_ready, s_req_valid} !== 2'b00) begin
      $display("FAIL fetch_c1_idle: got rdy/val=%b expected 00", {m0_req_ready, s_req_valid}); n_err++;
    end
    // cycle 2: REQ0
    step();
    #1;
    n_cmp++;
    if ({m0_req_ready, s_req_valid, s_addr, s_wen} !== {1'b1, 1'b1, 32'h8000_0000, 1'b0}) begin
      $display("FAIL fetch_c2_req: got rdy=%b val=%b addr=%h wen=%b expected 1 1 80000000 0",
               m0_req_ready, s_req_valid, s_addr, s_wen); n_err++;
    end
    // cycle 3: RSP0
    step();
    m0_req_valid = 1'b0; s_rsp_valid = 1'b1; s_rdata = 32'h0010_0073;
    #1;
    n_cmp++;
    if ({m0_rsp_valid, m0_rdata, s_rsp_ready, m0_req_ready, s_req_valid, s_wen}
        !== {1'b1, 32'h0010_0073, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL fetch_c3_rsp: got v=%b d=%h srdy=%b rrdy=%b sval=%b wen=%b expected 1 00100073 1 0 0 0",
               m0_rsp_valid, m0_rdata, s_rsp_ready, m0_req_ready, s_req_valid, s_wen); n_err++;
    end
    step();
    s_rsp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({dbg_state, m0_rsp_valid} !== {S_IDLE, 1'b0}) begin
      $display("FAIL fetch_done: got state=%0d rspv=%b expected 0 0", dbg_state, m0_rsp_valid); n_err++;
    end
  endtask

  task automatic test_contention_store();
    // fresh reset so last_grant is back at 1
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m0_req_valid = 1'b1; m0_addr = 32'h8000_0004; m0_rsp_ready = 1'b1;
    m1_req_valid = 1'b1; m1_addr = 32'h8000_1000; m1_wen = 1'b1;
    m1_wdata = 32'hDEAD_BEEF; m1_wmask = 4'hF; m1_rsp_ready = 1'b1;
    s_req_ready = 1'b1; s_rsp_valid = 1'b1; s_rdata = 32'h1111_1111;
    step();
    #1;
    n_cmp++;
    if ({m0_req_ready, m1_req_ready, s_addr, s_wen, s_wdata, s_wmask}
        !== {1'b1, 1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0}) begin
      $display("FAIL contend_m0_first: got r0=%b r1=%b addr=%h wen=%b wd=%h wm=%h expected 1 0 80000004 0 0 0",
               m0_req_ready, m1_req_ready, s_addr, s_wen, s_wdata, s_wmask); n_err++;
    end
    step();
    m0_req_valid = 1'b0;
    #1;
    n_cmp++;
    if ({m0_rsp_valid, m1_rsp_valid, m1_rdata, m1_req_ready} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      $display("FAIL contend_rsp0_isolation: got v0=%b v1=%b d1=%h r1=%b expected 1 0 0 0",
               m0_rsp_valid, m1_rsp_valid, m1_rdata, m1_req_ready); n_err++;
    end
    step();
    #1;
    n_cmp++;
    if ({dbg_state, m1_req_ready, s_req_valid} !== {S_IDLE, 1'b0, 1'b0}) begin
      $display("FAIL contend_idle_gap: got state=%0d r1=%b sval=%b expected 0 0 0",
               dbg_state, m1_req_ready, s_req_valid); n_err++;
    end
    step();
    #1;
    n_cmp++;
    if ({m1_req_ready, m0_req_ready, s_addr, s_wen, s_wdata, s_wmask}
        !== {1'b1, 1'b0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
      $display("FAIL contend_m1_store: got r1=%b r0=%b addr=%h wen=%b wd=%h wm=%h expected 1 0 80001000 1 deadbeef f",
               m1_req_ready, m0_req_ready, s_addr, s_wen, s_wdata, s_wmask); n_err++;
    end
    step();
    m1_req_valid = 1'b0;
    #1;
    n_cmp++;
    if ({dbg_state, m1_rsp_valid} !== {S_RSP1, 1'b1}) begin
      $display("FAIL contend_store_rsp: got state=%0d v1=%b expected 4 1", dbg_state, m1_rsp_valid); n_err++;
    end
    step();
    #1;
  endtask

  task automatic test_round_robin();
    logic [0:0] exp_q[$];
    int cyc = 0;
    int last_cyc = 0;
    int got = 0;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    m0_req_valid = 1'b1; m0_addr = 32'h8000_0100;
    m1_req_valid = 1'b1; m1_addr = 32'h8000_0200; m1_wen = 1'b0;
    while (got < 4 && cyc < 40) begin
      step();
      cyc++;
      if (m0_req_ready || m1_req_ready) begin
        logic [0:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        if ({m0_req_ready, m1_req_ready} !== {~e, e}) begin
          $display("FAIL rr_grant%0d: got r0/r1=%b expected %b", got, {m0_req_ready, m1_req_ready}, {~e, e}); n_err++;
        end
        if (got > 0) begin
          n_cmp++;
          if (cyc - last_cyc !== 3) begin
            $display("FAIL rr_spacing%0d: got %0d cycles expected 3", got, cyc - last_cyc); n_err++;
          end
        end
        last_cyc = cyc;
        got++;
      end
    end
    n_cmp++;
    if (got !== 4) begin
      $display("FAIL rr_timeout: got %0d grants expected 4", got); n_err++;
    end
    step();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    step();
    n_cmp++;
    if (dbg_state !== S_IDLE) begin
      $display("FAIL rr_drain: got state=%0d expected 0", dbg_state); n_err++;
    end
  endtask

  task automatic test_back_pressure();
    int n_rsp = 0;
    s_req_ready = 1'b0; s_rsp_valid = 1'b0; m1_rsp_ready = 1'b0;
    m1_req_valid = 1'b1; m1_addr = 32'h8000_2000; m1_wen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      m1_req_valid = (i != 2);
      #1;
      n_cmp++;
      if ({dbg_state, s_req_valid, m1_req_ready, s_addr} !== {S_REQ1, (i != 2), 1'b0, 32'h8000_2000}) begin
        $display("FAIL bp_req_hold%0d: got state=%0d sval=%b r1=%b addr=%h expected 3 %b 0 80002000",
                 i, dbg_state, s_req_valid, m1_req_ready, s_addr, (i != 2)); n_err++;
      end
    end
    step();
    m1_req_valid = 1'b1; s_req_ready = 1'b1;
    #1;
    n_cmp++;
    if ({dbg_state, m1_req_ready} !== {S_REQ1, 1'b1}) begin
      $display("FAIL bp_req_accept: got state=%0d r1=%b expected 3 1", dbg_state, m1_req_ready); n_err++;
    end
    step();
    m1_req_valid = 1'b0; s_req_ready = 1'b0; s_rsp_valid = 1'b1; s_rdata = 32'hCAFE_F00D;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step();
      m1_rsp_ready = (j == 3);
      m0_req_valid = (j == 3);
      m0_addr = 32'h8000_0010;
      #1;
      n_cmp++;
      if ({dbg_state, m1_rsp_valid, s_rsp_ready, m0_req_ready} !== {S_RSP1, 1'b1, (j == 3), 1'b0}) begin
        $display("FAIL bp_rsp_hold%0d: got state=%0d v1=%b srdy=%b r0=%b expected 4 1 %b 0",
                 j, dbg_state, m1_rsp_valid, s_rsp_ready, m0_req_ready, (j == 3)); n_err++;
      end
      if (m1_rsp_valid && m1_rsp_ready) n_rsp++;
    end
    n_cmp++;
    if (m1_rdata !== 32'hCAFE_F00D) begin
      $display("FAIL bp_rdata: got %h expected cafef00d", m1_rdata); n_err++;
    end
    step();
    #1;
    if (m1_rsp_valid && m1_rsp_ready) n_rsp++;
    n_cmp++;
    if ({dbg_state, m1_rsp_valid, m0_req_ready} !== {S_IDLE, 1'b0, 1'b0}) begin
      $display("FAIL bp_no_same_cycle_grant: got state=%0d v1=%b r0=%b expected 0 0 0",
               dbg_state, m1_rsp_valid, m0_req_ready); n_err++;
    end
    s_rsp_valid = 1'b0;
    step();
    n_cmp++;
    if (n_rsp !== 1) begin
      $display("FAIL bp_rsp_count: got %0d expected 1", n_rsp); n_err++;
    end
    n_cmp++;
    if (dbg_state !== S_REQ0) begin
      $display("FAIL held_req_granted: got state=%0d expected 1", dbg_state); n_err++;
    end
  endtask

  task automatic test_reset_mid_txn();
    s_req_ready = 1'b1; m0_rsp_ready = 1'b1;
    step();
    s_req_ready = 1'b0;
    m1_req_valid = 1'b1; m1_addr = 32'h8000_3000; m1_wen = 1'b0;
    #1;
    n_cmp++;
    if (dbg_state !== S_RSP0) begin
      $display("FAIL rstmid_in_rsp0: got state=%0d expected 2", dbg_state); n_err++;
    end
    rst = 1'b1; s_rsp_valid = 1'b1; s_rdata = 32'h0BAD_0BAD;
    #1;
    n_cmp++;
    if (all_out !== '0) begin
      $display("FAIL rstmid_outputs: got %h expected 0", all_out); n_err++;
    end
    step();
    rst = 1'b0; m0_req_valid = 1'b0; s_rsp_valid = 1'b0; s_req_ready = 1'b1;
    #1;
    n_cmp++;
    if ({dbg_state, m0_rsp_valid} !== {S_IDLE, 1'b0}) begin
      $display("FAIL rstmid_after: got state=%0d v0=%b expected 0 0", dbg_state, m0_rsp_valid); n_err++;
    end
    step();
    n_cmp++;
    if ({dbg_state, m1_req_ready, s_addr} !== {S_REQ1, 1'b1, 32'h8000_3000}) begin
      $display("FAIL rstmid_m1_grant: got state=%0d r1=%b addr=%h expected 3 1 80003000",
               dbg_state, m1_req_ready, s_addr); n_err++;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_m0_fetch();
    test_contention_store();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_txn();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
